mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_rr_picker.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared controller types for the GPU memory-side blocks.
//   arb_state_t : state of the memory port arbiter FSM (IDLE/ISSUE/RELAY)
//   mem_op_t    : kind of transaction a grant carries (read or write)
//   id_width()  : width of a consumer index, never less than one bit
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RELAY = 2'd2
  } arb_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_t;

  // A single consumer still needs a 1-bit index so the ports stay legal.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. Scans the request vector starting at
// i_rr_ptr and wrapping past NUM_CONSUMERS-1 back to 0; the first requester
// found wins.
//   i_req          : one request bit per consumer
//   i_rr_ptr       : index that has highest priority this scan
//   o_grant_valid  : at least one consumer is requesting
//   o_grant_id     : index of the winning consumer (0 when none)
// ---------------------------------------------------------------------------
module rr_picker
  import mem_port_arbiter_pkg::*;
#(
  parameter  int NUM_CONSUMERS = 2,
  localparam int ID_W          = id_width(NUM_CONSUMERS)
) (
  input  logic [NUM_CONSUMERS-1:0] i_req,
  input  logic [ID_W-1:0]          i_rr_ptr,
  output logic                     o_grant_valid,
  output logic [ID_W-1:0]          o_grant_id
);

  int w_idx;

  // Walk the offsets from farthest to nearest so the requester closest to
  // the pointer is the last one written, i.e. the winner.
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_id    = '0;
    w_idx         = 0;
    for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
      w_idx = (int'(i_rr_ptr) + k) % NUM_CONSUMERS;
      if (i_req[ID_W'(w_idx)]) begin
        o_grant_valid = 1'b1;
        o_grant_id    = ID_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one downstream memory (cache) port among NUM_CONSUMERS cores/LSUs.
// One transaction is outstanding at a time; consumers are served round-robin.
//
// Ports
//   clk, reset                 : rising-edge clock, synchronous active-high reset
//   consumer_read_valid/addr   : per-consumer read request (addr stable while valid)
//   consumer_read_ready/data   : per-consumer read completion and returned data
//   consumer_write_valid/addr/data : per-consumer write request
//   consumer_write_ready       : per-consumer write completion
//   mem_req/we/addr/wdata      : downstream request, held stable until mem_ready
//   mem_rdata, mem_ready       : downstream read data and one-cycle completion
//   o_dbg_state/rr_ptr/grant_id: FSM observation for checkers
//
// Handshake: a consumer raises valid and holds it (with address/data) until
// it sees its ready. Ready then stays high until the consumer drops the valid
// of the served type; ready clears on the following edge. If valid drops
// before completion the transaction still finishes and ready pulses for one
// cycle. Downstream, mem_req rises the cycle after the grant and every request
// field stays constant until a cycle in which mem_ready=1 is sampled.
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter  int NUM_CONSUMERS = 2,
  parameter  int ADDR_BITS     = 8,
  parameter  int DATA_BITS     = 8,
  localparam int ID_W          = id_width(NUM_CONSUMERS)
) (
  input  logic                                    clk,
  input  logic                                    reset,

  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,

  input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,

  output logic                                    mem_req,
  output logic                                    mem_we,
  output logic [ADDR_BITS-1:0]                    mem_addr,
  output logic [DATA_BITS-1:0]                    mem_wdata,
  input  logic [DATA_BITS-1:0]                    mem_rdata,
  input  logic                                    mem_ready,

  output arb_state_t                              o_dbg_state,
  output logic [ID_W-1:0]                         o_dbg_rr_ptr,
  output logic [ID_W-1:0]                         o_dbg_grant_id
);

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  arb_state_t                              r_state;
  arb_state_t                              w_state_next;
  logic [ID_W-1:0]                         r_rr_ptr;
  logic [ID_W-1:0]                         r_grant_id;
  mem_op_t                                 r_grant_op;
  logic                                    r_mem_req;
  logic                                    r_mem_we;
  logic [ADDR_BITS-1:0]                    r_mem_addr;
  logic [DATA_BITS-1:0]                    r_mem_wdata;
  logic [NUM_CONSUMERS-1:0]                r_read_ready;
  logic [NUM_CONSUMERS-1:0]                r_write_ready;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] r_read_data;

  // -------------------------------------------------------------------------
  // Combinational helpers
  // -------------------------------------------------------------------------
  logic [NUM_CONSUMERS-1:0] w_req_vec;
  logic                     w_pick_valid;
  logic [ID_W-1:0]          w_pick_id;
  logic                     w_pick_is_read;
  logic                     w_served_valid;
  logic [ID_W-1:0]          w_next_ptr;
  logic                     w_do_grant;
  logic                     w_do_complete;
  logic                     w_do_release;

  assign w_req_vec = consumer_read_valid | consumer_write_valid;

  rr_picker #(
    .NUM_CONSUMERS (NUM_CONSUMERS)
  ) u_rr_picker (
    .i_req         (w_req_vec),
    .i_rr_ptr      (r_rr_ptr),
    .o_grant_valid (w_pick_valid),
    .o_grant_id    (w_pick_id)
  );

  // A winner presenting both request types is served its read first.
  assign w_pick_is_read = consumer_read_valid[w_pick_id];

  // Only the valid of the type actually served releases the grant, so a
  // pending write on the same consumer does not hold a finished read open.
  assign w_served_valid = (r_grant_op == OP_READ) ? consumer_read_valid[r_grant_id]
                                                  : consumer_write_valid[r_grant_id];

  assign w_next_ptr = (r_grant_id == ID_W'(NUM_CONSUMERS - 1)) ? '0
                                                               : r_grant_id + ID_W'(1);

  // -------------------------------------------------------------------------
  // FSM: next state and control strobes
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_do_grant    = 1'b0;
    w_do_complete = 1'b0;
    w_do_release  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_do_grant   = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        // mem_ready is only meaningful here; other states never look at it.
        if (mem_ready) begin
          w_do_complete = 1'b1;
          w_state_next  = RELAY;
        end
      end
      RELAY: begin
        if (!w_served_valid) begin
          w_do_release = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_grant_op    <= OP_READ;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_read_ready  <= '0;
      r_write_ready <= '0;
      r_read_data   <= '0;
    end else begin
      if (w_do_grant) begin
        r_mem_req  <= 1'b1;
        r_mem_we   <= !w_pick_is_read;
        r_grant_id <= w_pick_id;
        r_grant_op <= w_pick_is_read ? OP_READ : OP_WRITE;
        if (w_pick_is_read) begin
          r_mem_addr  <= consumer_read_address[w_pick_id];
          r_mem_wdata <= '0;
        end else begin
          r_mem_addr  <= consumer_write_address[w_pick_id];
          r_mem_wdata <= consumer_write_data[w_pick_id];
        end
      end

      if (w_do_complete) begin
        r_mem_req <= 1'b0;
        if (r_grant_op == OP_READ) begin
          r_read_data[r_grant_id]  <= mem_rdata;
          r_read_ready[r_grant_id] <= 1'b1;
        end else begin
          r_write_ready[r_grant_id] <= 1'b1;
        end
      end

      if (w_do_release) begin
        r_read_ready  <= '0;
        r_write_ready <= '0;
        r_rr_ptr      <= w_next_ptr;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign consumer_read_ready  = r_read_ready;
  assign consumer_read_data   = r_read_data;
  assign consumer_write_ready = r_write_ready;
  assign mem_req              = r_mem_req;
  assign mem_we               = r_mem_we;
  assign mem_addr             = r_mem_addr;
  assign mem_wdata            = r_mem_wdata;
  assign o_dbg_state          = r_state;
  assign o_dbg_rr_ptr         = r_rr_ptr;
  assign o_dbg_grant_id       = r_grant_id;

endmodule
